// File: rtl/ps2_key_tracker.sv
// PS/2 device-to-host receiver with Set-2 make/break decode; tracks the single
// most recently pressed key for the keycode-to-tone lookup stage.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_down,
  output logic       new_key,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BRK    = 2'd1,
    S_EXT    = 2'd2,
    S_EXTBRK = 2'd3
  } state_t;

  // Handshake: byte_stb is a one-cycle valid with no ready; the decoder
  // always consumes byte_q in the cycle byte_stb is high.
  logic [2:0]    clk_sync;
  logic [2:0]    dat_sync;
  logic          fall;
  logic          bit_in;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [10:0]   frame;
  logic          frame_ok;
  logic [TW-1:0] to_cnt;
  logic          byte_stb;
  logic [7:0]    byte_q;

  state_t        state, state_n;
  logic [7:0]    key_n;
  logic          down_n;
  logic          new_n;

  // Sync flops reset high so the idle-high bus does not look like an edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= 3'b111;
      dat_sync <= 3'b111;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_data};
    end
  end

  assign fall   = ~clk_sync[1] & clk_sync[2];
  assign bit_in = dat_sync[2];

  // Bits arrive LSB first, so frame[0] is the start bit and frame[10] the stop bit.
  assign frame    = {bit_in, shreg};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      byte_stb  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        shreg  <= {bit_in, shreg[9:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_stb <= 1'b1;
            byte_q   <= frame[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TO_MAX) begin
          bit_cnt   <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= S_IDLE;
      keycode  <= 8'h00;
      key_down <= 1'b0;
      new_key  <= 1'b0;
    end else begin
      state    <= state_n;
      keycode  <= key_n;
      key_down <= down_n;
      new_key  <= new_n;
    end
  end

  always_comb begin
    state_n = state;
    key_n   = keycode;
    down_n  = key_down;
    new_n   = 1'b0;
    if (byte_stb) begin
      case (state)
        S_IDLE: begin
          if (byte_q == 8'hF0) begin
            state_n = S_BRK;
          end else if (byte_q == 8'hE0) begin
            state_n = S_EXT;
          end else if (!key_down || byte_q != keycode) begin
            // Last-pressed wins; a typematic repeat of the held key is silent.
            key_n  = byte_q;
            down_n = 1'b1;
            new_n  = 1'b1;
          end
        end
        S_BRK: begin
          if (byte_q == keycode) begin
            key_n  = 8'h00;
            down_n = 1'b0;
          end
          state_n = S_IDLE;
        end
        S_EXT:    state_n = (byte_q == 8'hF0) ? S_EXTBRK : S_IDLE;
        S_EXTBRK: state_n = S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scenarios plus random frames, with a
// sequence-level key model feeding an expected-pulse queue.
module tb_ps2_key_tracker;

  localparam int TO   = 300;
  localparam int H    = 8;
  localparam int GAP  = 12;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_down;
  logic       new_key;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  // Expected pulses: bit 8 set = frame_err, else new_key with keycode in [7:0].
  logic [8:0] exp_q[$];
  logic [7:0] pre[$];
  logic [7:0] m_key;
  logic       m_down;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_down  (key_down),
    .new_key   (new_key),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every pulse the DUT raises must match the head of the queue.
  always @(negedge clk) begin
    if (clrn) begin
      if (new_key && frame_err)
        check("pulse_overlap", 32'd1, 32'd0);
      if (new_key || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {23'd0, frame_err, keycode}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("pulse", {23'd0, frame_err, (new_key ? keycode : 8'h00)}, {23'd0, e});
        end
      end
    end
  end

  // Reference model: groups bytes into complete Set-2 sequences.
  task automatic model_byte(input logic [7:0] b);
    pre.push_back(b);
    if ((pre.size() == 1 && (b == 8'hF0 || b == 8'hE0)) ||
        (pre.size() == 2 && pre[0] == 8'hE0 && pre[1] == 8'hF0))
      return;
    if (pre.size() == 1) begin
      if (!m_down || b != m_key) begin
        m_key  = b;
        m_down = 1'b1;
        exp_q.push_back({1'b0, b});
      end
    end else if (pre.size() == 2 && pre[0] == 8'hF0) begin
      if (b == m_key) begin
        m_key  = 8'h00;
        m_down = 1'b0;
      end
    end
    pre.delete();
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b);
    if (bad_par) par = ~par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_keycode"}, {24'd0, keycode}, {24'd0, m_key});
    check({tag, "_key_down"}, {31'd0, key_down}, {31'd0, m_down});
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = make_frame(b, bad_par);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    if (bad_par) exp_q.push_back(9'h100);
    else model_byte(b);
    ps2_bit(f[10]);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    logic [10:0] f;
    f = make_frame(b, 1'b0);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic timeout_case(input logic [7:0] b, input int n);
    send_partial(b, n);
    exp_q.push_back(9'h100);
    repeat (TO + 20) @(negedge clk);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    exp_q.delete();
    pre.delete();
    m_key  = 8'h00;
    m_down = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_keycode", {24'd0, keycode}, 32'd0);
    check("rst_key_down", {31'd0, key_down}, 32'd0);
    check("rst_new_key", {31'd0, new_key}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    repeat (6) @(negedge clk);
    check({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] pool[8];
    logic [7:0] b;
    int r;
    pool = '{8'h16, 8'h1E, 8'h26, 8'h3E, 8'h1C, 8'hF0, 8'hE0, 8'h75};
    m_key  = 8'h00;
    m_down = 1'b0;
    do_reset();

    // Reset mid-frame
    send_partial(8'h1C, 5);
    do_reset();
    send_frame(8'h1C, 0);
    check_state("t1");
    drained("t1");

    // Press / repeat / release
    do_reset();
    send_frame(8'h16, 0);
    check_state("t2_press");
    send_frame(8'h16, 0);
    send_frame(8'h16, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h16, 0);
    check_state("t2_rel");
    drained("t2");

    // Overlap
    send_frame(8'h16, 0);
    send_frame(8'h1E, 0);
    check_state("t3_1e");
    send_frame(8'hF0, 0);
    send_frame(8'h16, 0);
    check_state("t3_f016");
    send_frame(8'hF0, 0);
    send_frame(8'h1E, 0);
    check_state("t3_f01e");
    drained("t3");

    // Bad parity then good
    send_frame(8'h26, 1);
    check_state("t4_bad");
    send_frame(8'h26, 0);
    check_state("t4_good");
    drained("t4");

    // Extended keys while 16 held
    send_frame(8'h16, 0);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    check_state("t5");
    drained("t5");

    // Timeout then valid frame
    timeout_case(8'h5A, 4);
    check_state("t6_to");
    send_frame(8'h3E, 0);
    check_state("t6");
    drained("t6");

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        timeout_case(8'($urandom), $urandom_range(1, 10));
      end else begin
        b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
        send_frame(b, r < 14);
      end
      check_state("rand");
    end
    drained("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
